// File: rtl/register_file_pkg.sv
// Shared CPU datapath constants and types for the general-purpose register file.
package register_file_pkg;

    localparam int unsigned REG_DATA_W = 16;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;
    localparam int unsigned REG_ZERO   = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// Two-read, one-write register file with r0 hardwired to zero.
// Reads are combinational; the single write and the synchronous reset happen on the clk rising edge.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = REG_DATA_W,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] Rs1,
    input  logic [ADDR_WIDTH-1:0] Rs2,
    input  logic [ADDR_WIDTH-1:0] Rd,
    input  logic [DATA_WIDTH-1:0] Write_data,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] Read_data1,
    output logic [DATA_WIDTH-1:0] Read_data2
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    // r0 has no storage, so the array starts at index 1.
    logic [DATA_WIDTH-1:0] r_regs [1:DEPTH-1];

    logic w_rs1_zero;
    logic w_rs2_zero;
    logic w_rd_zero;

    assign w_rs1_zero = (Rs1 == ZERO_IDX);
    assign w_rs2_zero = (Rs2 == ZERO_IDX);
    assign w_rd_zero  = (Rd  == ZERO_IDX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: this array is clearable flops, not a RAM macro, so resetting every entry is legal and intended.
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_regs[i] <= '0;
            end
        end else if (RegWrite && !w_rd_zero) begin
            r_regs[Rd] <= Write_data;
        end
    end

    // The r0 override keeps the out-of-range index 0 from ever being selected.
    assign Read_data1 = w_rs1_zero ? '0 : r_regs[Rs1];
    assign Read_data2 = w_rs2_zero ? '0 : r_regs[Rs2];

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file with hand-computed expected values.
module tb_register_file;
    import register_file_pkg::*;

    logic      clk;
    logic      reset;
    reg_addr_t Rs1, Rs2, Rd;
    reg_data_t Write_data;
    logic      RegWrite;
    reg_data_t Read_data1, Read_data2;

    int n_checks = 0;
    int n_errors = 0;

    register_file dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1        (Rs1),
        .Rs2        (Rs2),
        .Rd         (Rd),
        .Write_data (Write_data),
        .RegWrite   (RegWrite),
        .Read_data1 (Read_data1),
        .Read_data2 (Read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input reg_data_t got, input reg_data_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 16'h%h, expected 16'h%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge, well away from the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input reg_addr_t rd, input reg_data_t data);
        Rd         = rd;
        Write_data = data;
        RegWrite   = 1'b1;
        tick();
        RegWrite   = 1'b0;
    endtask

    task automatic read_both(input reg_addr_t a1, input reg_addr_t a2);
        Rs1 = a1;
        Rs2 = a2;
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        RegWrite   = 1'b0;
        Rs1        = '0;
        Rs2        = '0;
        Rd         = '0;
        Write_data = '0;

        // Reset: one edge low, then every index reads zero on both ports.
        #2;
        tick();
        reset = 1'b1;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            read_both(reg_addr_t'(i), reg_addr_t'(31 - i));
            check($sformatf("reset_rd1_r%0d", i), Read_data1, 16'h0000);
            check($sformatf("reset_rd2_r%0d", 31 - i), Read_data2, 16'h0000);
        end

        // Basic write/read.
        write_reg(5'd2, 16'h1234);
        write_reg(5'd3, 16'h5678);
        read_both(5'd2, 5'd3);
        check("basic_rd1_r2", Read_data1, 16'h1234);
        check("basic_rd2_r3", Read_data2, 16'h5678);

        // Both ports on the same register.
        read_both(5'd3, 5'd3);
        check("same_addr_rd1", Read_data1, 16'h5678);
        check("same_addr_rd2", Read_data2, 16'h5678);

        // Write disable.
        Rd         = 5'd3;
        Write_data = 16'hFFFF;
        RegWrite   = 1'b0;
        tick();
        read_both(5'd2, 5'd3);
        check("wr_disable_r3", Read_data2, 16'h5678);
        check("wr_disable_r2", Read_data1, 16'h1234);

        // r0 hardwire.
        write_reg(5'd0, 16'hABCD);
        read_both(5'd0, 5'd0);
        check("r0_rd1", Read_data1, 16'h0000);
        check("r0_rd2", Read_data2, 16'h0000);

        // Top index boundary.
        write_reg(5'd31, 16'hBEEF);
        read_both(5'd31, 5'd30);
        check("r31_rd1", Read_data1, 16'hBEEF);
        check("r30_rd2", Read_data2, 16'h0000);

        // Same-cycle read/write: old value before the edge, new after.
        write_reg(5'd5, 16'h1111);
        read_both(5'd5, 5'd2);
        Rd         = 5'd5;
        Write_data = 16'h00A5;
        RegWrite   = 1'b1;
        #1;
        check("rw_same_before", Read_data1, 16'h1111);
        tick();
        RegWrite = 1'b0;
        check("rw_same_after", Read_data1, 16'h00A5);
        check("rw_same_other", Read_data2, 16'h1234);

        // Read port follows a changing address with no clock.
        read_both(5'd31, 5'd5);
        check("comb_follow_rd1", Read_data1, 16'hBEEF);
        check("comb_follow_rd2", Read_data2, 16'h00A5);

        // Reset priority over a simultaneous write.
        write_reg(5'd7, 16'h0707);
        reset      = 1'b0;
        Rd         = 5'd7;
        Write_data = 16'h7777;
        RegWrite   = 1'b1;
        tick();
        reset    = 1'b1;
        RegWrite = 1'b0;
        read_both(5'd7, 5'd2);
        check("rst_prio_r7", Read_data1, 16'h0000);
        check("rst_prio_r2", Read_data2, 16'h0000);
        read_both(5'd3, 5'd31);
        check("rst_prio_r3", Read_data1, 16'h0000);
        check("rst_prio_r31", Read_data2, 16'h0000);

        // File is writable again after reset.
        write_reg(5'd7, 16'hC0DE);
        read_both(5'd7, 5'd7);
        check("post_rst_r7", Read_data1, 16'hC0DE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_register_file
